alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 8-bit combinational datapath ALU.
- Operand width is generic, and every result is registered behind a valid/ready output stage.
- Adds a true arithmetic right shift and an optional iterative multiplier.
- Sits between the register-read stage and writeback; the downstream stage may stall it.

Parameters:
WIDTH, 8, operand/result width in bits (power of two, >=4)
SHW, $clog2(WIDTH), shift-amount bits taken from rs2[SHW-1:0] (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request this cycle
rs1  input  WIDTH  operand A
rs2  input  WIDTH  operand B / shift amount
ctrl  input  3  opcode
flag  input  1  opcode modifier
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  WIDTH  registered result
overflow  output  1  registered overflow/carry
busy  output  1  multi-cycle operation in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, overflow=0, out_valid=0, busy=0, multiplier accumulator and counter cleared.
- A reset asserted mid-operation aborts any multiply and drops any pending result.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready. Operands and opcode are captured on that edge.
- Opcode 000, ADD (flag=0): out = rs1+rs2 mod 2^WIDTH; overflow = carry out.
- Opcode 000, SUB (flag=1): out = rs1+~rs2+1; overflow = signed overflow = (rs1[MSB]^rs2[MSB]) & (rs1[MSB]^out[MSB]).
- Opcode 001: flag=1 gives NAND, flag=0 gives NOR. overflow=0.
- Opcode 010: SLTU, out = {0..,1} if rs1<rs2 unsigned, else 0. flag ignored. overflow=0.
- Opcode 011: flag=1 gives SLL, flag=0 gives SRL, both by rs2[SHW-1:0]. overflow=0.
- Opcode 100: SRA by rs2[SHW-1:0]. Sign-fills from rs1[MSB]; this must be a genuine signed shift, not logical. overflow=0.
- Opcode 101: MUL (see Optional Feature).
- Opcodes 110/111: out=0, overflow=0, completes as a single-cycle op.
- Single-cycle ops: result loads into the output register on the accept edge. out_valid=1 from the next cycle.
- Output hold: out/overflow/out_valid are held stable while out_valid && !out_ready. out_valid clears on out_ready unless a new op is accepted the same edge (back-to-back: result replaced, out_valid stays 1).
- Throughput: one single-cycle op per clock when out_ready=1.
- States: IDLE -> MUL on accepted opcode 101 (feature enabled). MUL -> DONE after WIDTH iterations. DONE -> IDLE when the output register is free (!out_valid || out_ready), loading the product into the output register.
- busy = (state != IDLE).
- Inputs are ignored (not captured) whenever in_ready=0.
- Simultaneous out_ready and accept: the old result is consumed and the new one is written in the same edge; no bubble.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 101 is an unsigned shift-add multiply.
  - One rs2 bit is consumed per cycle into a 2*WIDTH accumulator; counter runs 0..WIDTH-1.
  - out = low WIDTH bits of the product; overflow = 1 if the high WIDTH bits are nonzero.
  - With out_ready=1, latency from the accept edge to out_valid=1 is WIDTH+2 cycles.
  - in_ready=0 throughout.
- Undefined: no MUL state, accumulator or counter is synthesised. Opcode 101 behaves as an invalid opcode (out=0, overflow=0, single-cycle). busy is tied 0.

Test Plan:
- WIDTH=8, ADD 0xFF+0x01 -> out=0x00, overflow=1, out_valid one cycle after accept. SUB 0x80-0x01 -> out=0x7F, overflow=1. SUB 0x05-0x03 -> out=0x02, overflow=0.
- SRA rs1=0x90, rs2=0x02 -> out=0xE4. SRL same operands -> 0x24. SLL 0x81 by 1 -> 0x02. SLTU 0x01<0xFF -> 0x01.
- Stall: issue ADD 0x10+0x20 with out_ready=0 for 5 cycles -> out=0x30 held, in_ready=0, second request not captured. Release out_ready -> next op accepted the same edge.
- Back-to-back: 4 ops on consecutive cycles with out_ready=1 -> 4 consecutive valid results in order, no bubbles.
- ALU_MUL_EN defined, MUL 0x0F*0x11 -> out=0xFF, overflow=0, out_valid at accept+10 cycles. MUL 0x10*0x10 -> out=0x00, overflow=1. With the macro undefined, MUL -> out=0x00, overflow=0 after 1 cycle.
- Assert rst_n=0 mid-MUL (cycle 3) -> out_valid, busy, out and overflow all 0 immediately. After release, in_ready=1 and the next ADD completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with a parametric operand width and a true arithmetic right shift.
// Define ALU_MUL_EN to build opcode 101 as an iterative unsigned shift-add multiplier.
//   state  | meaning
//   IDLE   | accepting requests; single-cycle ops load the output register on accept
//   MUL    | consuming one multiplier bit per cycle into the accumulator
//   DONE   | product ready; waits for the output register to be free
module alu_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       ctrl,
  input  logic             flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             busy
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_LOG  = 3'b001;
  localparam logic [2:0] OP_SLTU = 3'b010;
  localparam logic [2:0] OP_SH   = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             out_free, accept;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   sh;

  assign out_free  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign sh        = rs2[SHW-1:0];
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

  always_comb begin
    add_full = {1'b0, rs1} + {1'b0, rs2};
    sub_res  = rs1 + ~rs2 + WIDTH'(1);
    res      = '0;
    res_ovf  = 1'b0;
    case (ctrl)
      OP_ADD: begin
        if (flag) begin
          res     = sub_res;
          res_ovf = (rs1[WIDTH-1] ^ rs2[WIDTH-1]) & (rs1[WIDTH-1] ^ sub_res[WIDTH-1]);
        end else begin
          res     = add_full[WIDTH-1:0];
          res_ovf = add_full[WIDTH];
        end
      end
      OP_LOG:  res = flag ? ~(rs1 & rs2) : ~(rs1 | rs2);
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      OP_SH:   res = flag ? (rs1 << sh) : (rs1 >> sh);
      // Signed operand so the shift fills with rs1's sign bit.
      OP_SRA:  res = $unsigned($signed(rs1) >>> sh);
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  assign in_ready = (state_q == S_IDLE) && out_free;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ctrl == OP_MUL) begin
            state_d = S_MUL;
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, rs1};
            mplr_d  = rs2;
            cnt_d   = '0;
          end else begin
            out_d       = res;
            ovf_d       = res_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_free) begin
          out_d       = acc_q[WIDTH-1:0];
          ovf_d       = |acc_q[2*WIDTH-1:WIDTH];
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
`else
  // Without the multiplier opcode 101 falls into the invalid-opcode path (res = 0).
  assign in_ready = out_free;
  assign busy     = 1'b0;

  always_comb begin
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      out_d       = res;
      ovf_d       = res_ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8; follows ALU_MUL_EN for multiply expectations.
module tb_alu_pipe;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 2;
  localparam bit HAS_MUL = 1'b1;
`else
  localparam int MUL_LAT = 1;
  localparam bit HAS_MUL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         flag = 1'b0;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic [2:0]   ctrl = '0;
  logic         in_ready, out_valid, overflow, busy;
  logic [W-1:0] out;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [W:0] exp_q[$];
  logic [W:0] obs_q[$];
  int         obs_cyc[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .ctrl(ctrl), .flag(flag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .overflow(overflow), .busy(busy)
  );

  // Collects every result the DUT hands over on the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && out_valid && out_ready) begin
      obs_q.push_back({overflow, out});
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [W:0] model(input logic [2:0] c, input logic f,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic           v;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             n;
    r = '0;
    v = 1'b0;
    n = int'(b[2:0]);
    case (c)
      3'd0: begin
        if (f) begin
          r = a - b;
          v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
          s = {1'b0, a} + {1'b0, b};
          r = s[W-1:0];
          v = s[W];
        end
      end
      3'd1: r = f ? ~(a & b) : ~(a | b);
      3'd2: r = (a < b) ? 8'h01 : 8'h00;
      3'd3: begin
        r = a;
        for (int i = 0; i < n; i++) r = f ? {r[W-2:0], 1'b0} : {1'b0, r[W-1:1]};
      end
      3'd4: begin
        r = a;
        for (int i = 0; i < n; i++) r = {a[W-1], r[W-1:1]};
      end
      3'd5: begin
        if (HAS_MUL) begin
          p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
          r = p[W-1:0];
          v = |p[2*W-1:W];
        end
      end
      default: ;
    endcase
    return {v, r};
  endfunction

  // Presents one request and returns #2 after the edge that accepted it.
  task automatic issue(input logic [2:0] c, input logic f, input logic [W-1:0] a, input logic [W-1:0] b);
    bit rdy;
    bit ok;
    ctrl = c; flag = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #2;
      ok = rdy;
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back(model(c, f, a, b));
    else begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout got no accept, need accept of op %0d", c);
    end
  endtask

  task automatic wait_results(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= exp_q.size()) ok = 1'b1;
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out got %h need 00", out); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b need 0", overflow); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b need 0", busy); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
    @(posedge clk); #2;
  endtask

  task automatic test_arith;
    bit ok;
    logic [W:0] e, o;
    out_ready = 1'b1;
    issue(3'd0, 1'b0, 8'hFF, 8'h01);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency got out_valid=%b need 1", out_valid); end
    issue(3'd0, 1'b1, 8'h80, 8'h01);
    issue(3'd0, 1'b1, 8'h05, 8'h03);
    issue(3'd0, 1'b0, 8'h7F, 8'h01);
    issue(3'd1, 1'b1, 8'hF0, 8'h3C);
    issue(3'd1, 1'b0, 8'hF0, 8'h3C);
    issue(3'd2, 1'b0, 8'h01, 8'hFF);
    issue(3'd2, 1'b1, 8'hFF, 8'h01);
    issue(3'd6, 1'b0, 8'h12, 8'h34);
    issue(3'd7, 1'b1, 8'hFF, 8'hFF);
    wait_results(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL arith_timeout got %0d results need %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL arith_result got out=%h ovf=%b need out=%h ovf=%b", o[W-1:0], o[W], e[W-1:0], e[W]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_shift;
    bit ok;
    logic [W:0] e, o;
    issue(3'd4, 1'b0, 8'h90, 8'h02);
    issue(3'd3, 1'b0, 8'h90, 8'h02);
    issue(3'd3, 1'b1, 8'h81, 8'h01);
    issue(3'd4, 1'b1, 8'h70, 8'h03);
    issue(3'd4, 1'b0, 8'h80, 8'hF7);
    issue(3'd3, 1'b1, 8'hA5, 8'h0F);
    wait_results(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL shift_timeout got %0d results need %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL shift_result got out=%h ovf=%b need out=%h ovf=%b", o[W-1:0], o[W], e[W-1:0], e[W]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_stall;
    bit ok;
    logic [W:0] e, o;
    out_ready = 1'b0;
    issue(3'd0, 1'b0, 8'h10, 8'h20);
    ctrl = 3'd0; flag = 1'b0; rs1 = 8'h01; rs2 = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b need 0", in_ready); end
      n_checks++; if (out !== 8'h30 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got out=%h valid=%b need out=30 valid=1", out, out_valid); end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b need 1", in_ready); end
    @(posedge clk); #2;
    in_valid = 1'b0;
    exp_q.push_back(model(3'd0, 1'b0, 8'h01, 8'h01));
    n_checks++; if (out !== 8'h02 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_same_edge got out=%h valid=%b need out=02 valid=1", out, out_valid); end
    wait_results(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got %0d results need %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL stall_count got %0d results need 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stall_result got out=%h ovf=%b need out=%h ovf=%b", o[W-1:0], o[W], e[W-1:0], e[W]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [W:0] e, o;
    int c0;
    out_ready = 1'b1;
    issue(3'd0, 1'b0, 8'h01, 8'h02);
    issue(3'd0, 1'b1, 8'h10, 8'h01);
    issue(3'd4, 1'b0, 8'h80, 8'h07);
    issue(3'd2, 1'b0, 8'hFF, 8'h01);
    wait_results(ok);
    n_checks++; if (!ok || obs_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_count got %0d results need 4", obs_q.size()); end
    else begin
      c0 = obs_cyc[0];
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (obs_cyc[i] != c0 + i) begin n_fail++; $display("FAIL b2b_bubble got result %0d at cycle %0d need cycle %0d", i, obs_cyc[i], c0 + i); end
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_result got out=%h ovf=%b need out=%h ovf=%b", o[W-1:0], o[W], e[W-1:0], e[W]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_mul;
    bit ok;
    logic [W:0] e, o;
    int lat;
    out_ready = 1'b1;
    issue(3'd5, 1'b0, 8'h0F, 8'h11);
    n_checks++; if (busy !== HAS_MUL) begin n_fail++; $display("FAIL mul_busy got %b need %b", busy, HAS_MUL); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (HAS_MUL && in_ready !== 1'b0) begin
        n_checks++; n_fail++; $display("FAIL mul_in_ready got %b need 0 at latency %0d", in_ready, lat);
      end
      @(posedge clk); #2;
      lat++;
    end
    n_checks++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL mul_latency got %0d need %0d", lat, MUL_LAT); end
    issue(3'd5, 1'b0, 8'h10, 8'h10);
    issue(3'd5, 1'b0, 8'hFF, 8'hFF);
    wait_results(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mul_timeout got %0d results need %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mul_result got out=%h ovf=%b need out=%h ovf=%b", o[W-1:0], o[W], e[W-1:0], e[W]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset_mid_mul;
    bit ok;
    logic [W:0] e, o;
    out_ready = 1'b0;
    issue(3'd5, 1'b0, 8'h0F, 8'h11);
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (busy !== HAS_MUL) begin n_fail++; $display("FAIL midmul_busy got %b need %b", busy, HAS_MUL); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_flags got valid=%b busy=%b need 0 0", out_valid, busy); end
    n_checks++; if (out !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL midmul_reset_data got out=%h ovf=%b need 00 0", out, overflow); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midmul_in_ready got %b need 1", in_ready); end
    @(posedge clk); #2;
    out_ready = 1'b1;
    issue(3'd0, 1'b0, 8'h03, 8'h04);
    wait_results(ok);
    n_checks++; if (!ok || obs_q.size() != 1) begin n_fail++; $display("FAIL midmul_count got %0d results need 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL midmul_result got out=%h ovf=%b need out=%h ovf=%b", o[W-1:0], o[W], e[W-1:0], e[W]); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_stall();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stray_results got %0d need 0", obs_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
